// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, funct fields and
// the enums used by decode, the ALU and the control FSM.
package mc_cpu_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_LUI
    } alu_op_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_B,
        IMM_U
    } imm_t;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write
// port, x0 hard-wired to zero, plus a direct view of x10.
module mc_regfile
    import mc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         raddr1,
    input  logic [AW-1:0]         raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] x10
);

    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

    // Synchronous clear on reset; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with x0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
        x10    = regs[10];
    end

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle RV32-subset core: FETCH/DECODE/EXECUTE/WRITEBACK with a
// sticky HALT on illegal encodings or misaligned branch targets.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  retire,
    output logic                  halted
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] pc, op_a, op_b, imm_q, result_q, target_q;
    logic [31:0]           ir;
    logic                  taken_q;

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       legal, wr_en, is_br, alu_imm, use_rd, use_rs1, use_rs2, illegal;
    alu_op_t    alu_op;
    imm_t       imm_sel;

    logic [DATA_WIDTH-1:0] imm, rdata1, rdata2, alu_b, alu_y, target;
    logic                  br_take;

    // Indices 16..31 do not exist in a 16-entry file
    function automatic logic idx_bad(input logic [4:0] idx);
        return (NUM_REGS == 16) && idx[4];
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    // Instruction decode and legality check from the instruction register
    always_comb begin
        legal   = 1'b0;
        wr_en   = 1'b0;
        is_br   = 1'b0;
        alu_imm = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        alu_op  = ALU_ADD;
        imm_sel = IMM_I;
        case (opcode)
            OP_IMM: begin
                if (f3 == F3_ADD) begin
                    legal   = 1'b1;
                    wr_en   = 1'b1;
                    alu_imm = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                end
            end
            OP_REG: begin
                if ((f3 == F3_ADD) && ((f7 == F7_ADD) || (f7 == F7_SUB))) begin
                    legal   = 1'b1;
                    wr_en   = 1'b1;
                    alu_op  = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_BRANCH: begin
                if ((f3 == F3_BEQ) || (f3 == F3_BNE)) begin
                    legal   = 1'b1;
                    is_br   = 1'b1;
                    imm_sel = IMM_B;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_LUI: begin
                legal   = 1'b1;
                wr_en   = 1'b1;
                alu_op  = ALU_LUI;
                imm_sel = IMM_U;
                use_rd  = 1'b1;
            end
            default: ;
        endcase
        illegal = !legal || (use_rd && idx_bad(rd)) ||
                  (use_rs1 && idx_bad(rs1)) || (use_rs2 && idx_bad(rs2));
    end

    // Sign-extended immediate at full datapath width
    always_comb begin
        case (imm_sel)
            IMM_I:   imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
            IMM_B:   imm = {{(DATA_WIDTH-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {{(DATA_WIDTH-31){ir[31]}}, ir[30:12], 12'h000};
            default: imm = '0;
        endcase
    end

    // ALU and branch evaluation on the operands latched in DECODE
    always_comb begin
        alu_b = alu_imm ? imm_q : op_b;
        case (alu_op)
            ALU_ADD: alu_y = op_a + alu_b;
            ALU_SUB: alu_y = op_a - op_b;
            ALU_LUI: alu_y = imm_q;
            default: alu_y = '0;
        endcase
        br_take = is_br && ((f3 == F3_BNE) ? (op_a != op_b) : (op_a == op_b));
        target  = pc + imm_q;
    end

    mc_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .raddr1(rs1[AW-1:0]),
        .raddr2(rs2[AW-1:0]),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .we    ((state == WRITEBACK) && wr_en),
        .waddr (rd[AW-1:0]),
        .wdata (result_q),
        .x10   (a0)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and control outputs
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        imem_addr = pc;
        case (state)
            FETCH: begin
                imem_req = !rst;
                if (imem_valid) state_nxt = DECODE;
            end
            DECODE:    state_nxt = illegal ? HALT : EXECUTE;
            EXECUTE:   state_nxt = (br_take && (target[1:0] != 2'b00)) ? HALT : WRITEBACK;
            WRITEBACK: begin
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT:      halted = 1'b1;
            default:   state_nxt = FETCH;
        endcase
    end

    // Datapath registers, each loaded in the state that produces it
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            imm_q    <= '0;
            result_q <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            case (state)
                FETCH:     if (imem_valid) ir <= imem_rdata;
                DECODE: begin
                    op_a  <= rdata1;
                    op_b  <= rdata2;
                    imm_q <= imm;
                end
                EXECUTE: begin
                    result_q <= alu_y;
                    taken_q  <= br_take;
                    target_q <= target;
                end
                WRITEBACK: pc <= taken_q ? target_q : (pc + PC_STEP);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: a 32-bit core with a wait-state imem model
// and a 64-bit, 16-register core running a LUI / bad-index program.
module tb_mc_cpu;

    localparam logic [31:0] BEQ_SELF = 32'h00000063; // beq x0,x0,0
    localparam logic [31:0] ADDI_5   = 32'h00500513; // addi x10,x0,5
    localparam logic [31:0] DEC_A0   = 32'hFFF50513; // addi x10,x10,-1
    localparam logic [31:0] ADDI_3   = 32'h00300513; // addi x10,x0,3
    localparam logic [31:0] ADDI_7   = 32'h00700513; // addi x10,x0,7
    localparam logic [31:0] INC_A0   = 32'h00150513; // addi x10,x10,1
    localparam logic [31:0] BNE_M4   = 32'hFE051EE3; // bne x10,x0,-4
    localparam logic [31:0] ADD_X0   = 32'h00A50033; // add x0,x10,x10
    localparam logic [31:0] ADD_X11  = 32'h000005B3; // add x11,x0,x0
    localparam logic [31:0] MV_A0    = 32'h00058533; // add x10,x11,x0
    localparam logic [31:0] ADDI_X12 = 32'h00900613; // addi x12,x0,9
    localparam logic [31:0] SUB_A0   = 32'h40C50533; // sub x10,x10,x12
    localparam logic [31:0] LUI_A0   = 32'hFFFFF537; // lui x10,0xFFFFF
    localparam logic [31:0] ADDI_X16 = 32'h00100813; // addi x16,x0,1
    localparam logic [31:0] BEQ_P2   = 32'h00000163; // beq x0,x0,+2
    localparam logic [31:0] ILLEGAL  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req32, valid32, ret32, halt32;
    logic [31:0] addr32, rdata32, a0_32;
    logic        req64, valid64, ret64, halt64;
    logic [63:0] addr64, a0_64;
    logic [31:0] rdata64;

    logic [31:0] mem   [0:15];
    logic [31:0] mem64 [0:15];
    int unsigned wait_n;
    int unsigned cnt;
    logic        force_valid;

    int n_assert;
    int n_fail;
    int bne_cnt;
    logic [31:0] last_addr;

    assign rdata32 = mem[addr32[5:2]];
    assign valid32 = (req32 && (cnt >= wait_n)) || force_valid;
    assign rdata64 = mem64[addr64[5:2]];
    assign valid64 = req64;

    always @(posedge clk) begin
        if (!req32 || valid32) cnt <= 0;
        else cnt <= cnt + 1;
    end

    mc_cpu #(.DATA_WIDTH(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(req32), .imem_addr(addr32),
        .imem_rdata(rdata32), .imem_valid(valid32), .a0(a0_32),
        .retire(ret32), .halted(halt32)
    );

    mc_cpu #(.DATA_WIDTH(64), .NUM_REGS(16), .RESET_PC(64'h0)) dut64 (
        .clk(clk), .rst(rst), .imem_req(req64), .imem_addr(addr64),
        .imem_rdata(rdata64), .imem_valid(valid64), .a0(a0_64),
        .retire(ret64), .halted(halt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 16; i++) mem[i] = BEQ_SELF;
    endtask

    // Leaves the bench in cycle 1 after reset release
    task automatic do_reset();
        rst = 1'b1;
        force_valid = 1'b0;
        tick();
        tick();
        chk("req_in_reset", req32, 1'b0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b1;
        wait_n = 0;
        force_valid = 1'b0;
        for (int i = 0; i < 16; i++) mem64[i] = BEQ_SELF;
        mem64[0] = LUI_A0;
        mem64[1] = ADDI_X16;

        // Two ADDIs, zero-wait memory
        load_mem();
        mem[0] = ADDI_5;
        mem[1] = DEC_A0;
        do_reset();
        chk("rst_req", req32, 1'b1);
        chk("rst_addr", addr32, 32'h0);
        chk("rst_halted", halt32, 1'b0);
        chk("rst_a0", a0_32, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            chk("t1_retire", ret32, (k == 4 || k == 8));
            if (k == 5) begin
                chk("t1_a0_5", a0_32, 32'd5);
                chk("w64_a0_lui", a0_64, 64'hFFFF_FFFF_FFFF_F000);
                chk("w64_not_halted", halt64, 1'b0);
            end
            if (k == 9) begin
                chk("t1_a0_4", a0_32, 32'd4);
                chk("w64_bad_reg_halt", halt64, 1'b1);
                chk("w64_a0_frozen", a0_64, 64'hFFFF_FFFF_FFFF_F000);
            end
            if (k < 9) tick();
        end

        // Three wait states on the fetch
        load_mem();
        mem[0] = ADDI_5;
        wait_n = 3;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) begin
                chk("t2_req_held", req32, 1'b1);
                chk("t2_addr_held", addr32, 32'h0);
            end else if (k <= 7) begin
                chk("t2_req_low", req32, 1'b0);
            end
            chk("t2_retire", ret32, (k == 7));
            if (k == 8) chk("t2_a0", a0_32, 32'd5);
            if (k < 8) tick();
        end
        wait_n = 0;

        // Countdown loop
        load_mem();
        mem[0] = ADDI_3;
        mem[1] = DEC_A0;
        mem[2] = BNE_M4;
        do_reset();
        bne_cnt = 0;
        last_addr = '1;
        for (int k = 1; k <= 40; k++) begin
            if (req32 && valid32) last_addr = addr32;
            if (ret32 && last_addr == 32'd8) bne_cnt++;
            tick();
        end
        chk("t3_bne_count", bne_cnt, 3);
        chk("t3_a0", a0_32, 32'd0);
        chk("t3_pc", addr32, 32'd12);
        chk("t3_halted", halt32, 1'b0);

        // x0 writes discarded, x11 from x0+x0, SUB wrap
        load_mem();
        mem[0] = ADDI_5;
        mem[1] = ADD_X0;
        mem[2] = ADD_X11;
        mem[3] = MV_A0;
        mem[4] = ADDI_X12;
        mem[5] = SUB_A0;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            if (k == 13) chk("t4_a0_before", a0_32, 32'd5);
            if (k == 17) chk("t4_x11_zero", a0_32, 32'd0);
            if (k == 25) chk("t4_sub_wrap", a0_32, 32'hFFFF_FFF7);
            if (k < 25) tick();
        end

        // Illegal word after one good instruction, then recovery by reset
        load_mem();
        mem[0] = ADDI_5;
        mem[1] = ILLEGAL;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            chk("t5_retire", ret32, (k == 4));
            if (k == 6) chk("t5_not_yet", halt32, 1'b0);
            if (k >= 7) begin
                chk("t5_halted", halt32, 1'b1);
                chk("t5_req_off", req32, 1'b0);
            end
            if (k == 12) begin
                chk("t5_a0_frozen", a0_32, 32'd5);
                chk("t5_pc_frozen", addr32, 32'd4);
            end
            if (k < 12) tick();
        end
        do_reset();
        chk("t5_rst_halted", halt32, 1'b0);
        chk("t5_rst_pc", addr32, 32'h0);
        chk("t5_rst_a0", a0_32, 32'h0);
        chk("t5_rst_req", req32, 1'b1);

        // Taken branch to a misaligned target
        load_mem();
        mem[0] = BEQ_P2;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            chk("t6_retire", ret32, 1'b0);
            if (k == 3) chk("t6_not_yet", halt32, 1'b0);
            if (k >= 4) chk("t6_halted", halt32, 1'b1);
            if (k == 6) chk("t6_pc", addr32, 32'h0);
            if (k < 6) tick();
        end

        // Reset during a pending fetch with a stale valid
        load_mem();
        mem[0] = ADDI_7;
        mem[1] = INC_A0;
        do_reset();
        tick();
        tick();
        tick();
        wait_n = 10;
        tick();
        chk("t7_pending_req", req32, 1'b1);
        chk("t7_pending_addr", addr32, 32'd4);
        tick();
        mem[1] = ILLEGAL;
        force_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("t7_req_rst", req32, 1'b0);
        tick();
        chk("t7_req_rst2", req32, 1'b0);
        chk("t7_halt_rst", halt32, 1'b0);
        rst = 1'b0;
        force_valid = 1'b0;
        wait_n = 0;
        mem[1] = INC_A0;
        #1;
        chk("t7_refetch_req", req32, 1'b1);
        chk("t7_refetch_addr", addr32, 32'h0);
        chk("t7_a0_cleared", a0_32, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            chk("t7_retire", ret32, (k == 4 || k == 8));
            if (k == 5) chk("t7_a0_7", a0_32, 32'd7);
            if (k == 9) chk("t7_a0_8", a0_32, 32'd8);
            if (k < 9) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
